// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one UART byte transmitter
// between NUM_REQ valid/ready byte sources. Each accepted byte is held on
// uart_tx_data, uart_tx_start is raised one cycle later, and the block then waits
// for the transmitter's clear_req pulse. It finishes with an idle gap so that
// the transmitter sees a fresh 0->1 edge on the next start.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_mask,
    output logic                 uart_tx_start,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_clear_req,
    input  logic                 uart_busy,
    output logic                 active,
    output logic [2:0]           active_id,
    output logic                 done,
    output logic [2:0]           done_id,
    output logic [15:0]          tx_count,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t      state;
    logic [2:0]  last_grant;
    logic [2:0]  grant_idx;
    logic        grant_found;
    logic [3:0]  cand;
    logic [7:0]  elig8;
    logic [7:0]  grant_data;
    logic [31:0] wait_cnt;
    logic [15:0] gap_cnt;

    // Busy is informational only; sequencing relies on clear_req.
    logic unused_busy;
    assign unused_busy = uart_busy;

    // Round-robin search: first eligible requester above last_grant, wrapping.
    always_comb begin
        elig8       = 8'(req_valid & req_mask);
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 4'(last_grant) + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!grant_found && elig8[cand[2:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
    end

    // Select the granted byte and raise the one-hot accept only while idle.
    always_comb begin
        grant_data = '0;
        req_ready  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                grant_data   = req_data[8*i +: 8];
                req_ready[i] = (state == IDLE) && grant_found;
            end
        end
    end

    // Transfer sequencer with registered outputs, completion counter and sticky timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 3'(NUM_REQ - 1);
            uart_tx_start <= 1'b0;
            uart_tx_data  <= 8'h00;
            active        <= 1'b0;
            active_id     <= '0;
            done          <= 1'b0;
            done_id       <= '0;
            tx_count      <= '0;
            timeout_err   <= 1'b0;
            wait_cnt      <= '0;
            gap_cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        uart_tx_data <= grant_data;
                        active_id    <= grant_idx;
                        last_grant   <= grant_idx;
                        active       <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    uart_tx_start <= 1'b1;
                    wait_cnt      <= '0;
                    state         <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (uart_clear_req) begin
                        uart_tx_start <= 1'b0;
                        done          <= 1'b1;
                        done_id       <= active_id;
                        tx_count      <= tx_count + 16'd1;
                        gap_cnt       <= 16'(GAP_CYCLES - 1);
                        state         <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (err_clr) begin
                timeout_err <= 1'b0;
            end else if (state == WAIT_DONE && !uart_clear_req &&
                         wait_cnt == TIMEOUT_CYC - 32'd1) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [3:0]  req_mask = '0;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_data;
    logic        uart_clear_req;
    logic        uart_busy;
    logic        active;
    logic [2:0]  active_id;
    logic        done;
    logic [2:0]  done_id;
    logic [15:0] tx_count;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYC(32'(TMO))) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_mask(req_mask), .uart_tx_start(uart_tx_start),
        .uart_tx_data(uart_tx_data), .uart_clear_req(uart_clear_req),
        .uart_busy(uart_busy), .active(active), .active_id(active_id), .done(done),
        .done_id(done_id), .tx_count(tx_count), .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transmitter stand-in: latches the byte on each start rise, answers with
    // clear_req after a frame length, and measures start-low gaps.
    logic       tx_clear = 1'b0;
    logic       stray_clr = 1'b0;
    int         tx_left = 0;
    int         frame_len = 10;
    bit         tx_silent = 0;
    bit         rand_frame = 0;
    bit         tx_prev = 0;
    bit         seen_rise = 0;
    int         low_run = 0;
    int         min_low = 1000;
    logic [7:0] tx_latched = '0;
    logic [7:0] tx_before = '0;
    logic [7:0] tx_prev_data = '0;

    assign uart_clear_req = tx_clear | stray_clr;
    assign uart_busy = (tx_left != 0);

    always @(posedge clk) begin
        #2;
        tx_clear = 1'b0;
        if (!rst_n) begin
            tx_left = 0;
            tx_prev = 0;
            low_run = 0;
        end else begin
            if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) tx_clear = 1'b1;
            end
            if (uart_tx_start && !tx_prev) begin
                tx_latched = uart_tx_data;
                tx_before  = tx_prev_data;
                if (seen_rise && low_run < min_low) min_low = low_run;
                seen_rise = 1;
                if (!tx_silent) tx_left = rand_frame ? int'($urandom_range(24, 1)) : frame_len;
            end
            low_run      = uart_tx_start ? 0 : low_run + 1;
            tx_prev      = uart_tx_start;
            tx_prev_data = uart_tx_data;
        end
    end

    // Reference model: one transfer at a time described by its age since accept.
    bit         m_busy, m_completed, m_done, m_err, set_to;
    int         m_age, m_gap, m_last, m_id, m_done_id, e_g;
    logic [7:0] m_data;
    logic [15:0] m_cnt;
    logic [3:0] e_elig, e_ready;
    int         grants[$];

    function automatic void model_reset();
        m_busy = 0; m_completed = 0; m_done = 0; m_err = 0;
        m_age = 0; m_gap = 0; m_last = N - 1; m_id = 0; m_done_id = 0;
        m_data = '0; m_cnt = '0;
    endfunction

    initial model_reset();

    // Per-cycle comparison of every output, then advance the model on the sampled inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_start", uart_tx_start, 0);
            chk("rst_data", uart_tx_data, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_active", active, 0);
            chk("rst_active_id", active_id, 0);
            chk("rst_done", done, 0);
            chk("rst_done_id", done_id, 0);
            chk("rst_tx_count", tx_count, 0);
            chk("rst_timeout", timeout_err, 0);
            model_reset();
        end else begin
            e_elig = req_valid & req_mask;
            e_g = -1;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (e_g < 0 && e_elig[(m_last + k) % N]) e_g = (m_last + k) % N;
                end
            end
            e_ready = (e_g >= 0) ? 4'(1 << e_g) : 4'b0;
            chk("ready", req_ready, e_ready);
            chk("start", uart_tx_start, (m_busy && !m_completed && m_age >= 1) ? 1 : 0);
            chk("data", uart_tx_data, m_data);
            chk("active", active, m_busy);
            chk("active_id", active_id, m_id);
            chk("done", done, m_done);
            if (m_done) chk("done_id", done_id, m_done_id);
            chk("tx_count", tx_count, m_cnt);
            chk("timeout_err", timeout_err, m_err);
            for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);

            m_done = 0;
            set_to = 0;
            if (!m_busy) begin
                if (e_g >= 0) begin
                    m_busy = 1; m_age = 0; m_completed = 0;
                    m_id = e_g; m_last = e_g; m_data = req_data[8*e_g +: 8];
                end
            end else if (!m_completed) begin
                if (m_age >= 1 && uart_clear_req) begin
                    m_completed = 1; m_gap = GAP; m_done = 1;
                    m_done_id = m_id; m_cnt = m_cnt + 16'd1;
                end else begin
                    if (m_age == TMO) set_to = 1;
                    m_age++;
                end
            end else begin
                m_gap--;
                if (m_gap == 0) m_busy = 0;
            end
            if (err_clr) m_err = 0;
            else if (set_to) m_err = 1;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        cycle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic wait_dones(input int want, input int budget, string name);
        int n;
        n = 0;
        for (int i = 0; i < budget && n < want; i++) begin
            cycle();
            if (done) n++;
        end
        if (n < want) chk({name, "_bound"}, n, want);
    endtask

    task automatic wait_start(input int budget, string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (uart_tx_start) begin ok = 1; break; end
        end
        if (!ok) chk({name, "_bound"}, 0, 1);
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_mk[4] = '{1, 3, 1, 3};
    bit stray_seen;
    bit got;

    initial begin
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        cycle();

        // Single byte from requester 2 with a 40-cycle frame.
        frame_len = 40;
        grants.delete();
        req_mask = 4'hF;
        req_data = 32'h00A5_0000;
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b0000;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (done) begin got = 1; break; end
        end
        chk("single_done", got, 1);
        chk("single_done_id", done_id, 2);
        chk("single_count", tx_count, 1);
        chk("single_grants", grants.size(), 1);
        if (grants.size() > 0) chk("single_grant_id", grants[0], 2);
        chk("single_latched", tx_latched, 8'hA5);
        chk("single_data_early", tx_before, 8'hA5);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        repeat (5) cycle();

        // Stray completion while idle.
        stray_seen = 0;
        stray_clr = 1'b1;
        cycle();
        stray_clr = 1'b0;
        if (done) stray_seen = 1;
        repeat (4) begin cycle(); if (done) stray_seen = 1; end
        chk("stray_done", stray_seen, 0);
        chk("stray_count", tx_count, 1);

        // Round robin from reset, all four requesters valid.
        do_reset();
        frame_len = 10;
        min_low = 1000;
        seen_rise = 0;
        grants.delete();
        req_data = 32'h1312_1110;
        req_valid = 4'hF;
        wait_dones(5, 2000, "rr");
        req_valid = 4'h0;
        chk("rr_grants", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", grants[i], exp_rr[i]);
        chk("rr_count", tx_count, 5);
        chk("rr_gap_ge2", (min_low >= 2) ? 1 : 0, 1);
        repeat (GAP + 2) cycle();

        // Masked requesters 0 and 2.
        grants.delete();
        req_mask = 4'b1010;
        req_valid = 4'hF;
        wait_dones(4, 2000, "mask");
        req_valid = 4'h0;
        chk("mask_grants", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("mask_order", grants[i], exp_mk[i]);
        repeat (GAP + 2) cycle();
        req_mask = 4'hF;

        // Timeout with a silent transmitter, then clear and late completion.
        tx_silent = 1;
        req_valid = 4'b0001;
        wait_start(20, "tmo_start");
        req_valid = 4'b0000;
        repeat (15) cycle();
        chk("tmo_not_yet", timeout_err, 0);
        cycle();
        chk("tmo_set", timeout_err, 1);
        chk("tmo_start_high", uart_tx_start, 1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("tmo_cleared", timeout_err, 0);
        cycle();
        chk("tmo_stays_clear", timeout_err, 0);
        stray_clr = 1'b1;
        cycle();
        stray_clr = 1'b0;
        chk("tmo_late_done", done, 1);
        chk("tmo_late_done_id", done_id, 0);
        tx_silent = 0;
        repeat (GAP + 2) cycle();

        // Asynchronous reset in the middle of a transfer owned by requester 0.
        frame_len = 40;
        req_valid = 4'b0001;
        wait_start(20, "mid_start");
        req_valid = 4'b0000;
        repeat (5) cycle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", uart_tx_start, 0);
        chk("mid_rst_count", tx_count, 0);
        chk("mid_rst_active", active, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        grants.delete();
        req_valid = 4'hF;
        for (int i = 0; i < 20 && grants.size() == 0; i++) cycle();
        chk("mid_rst_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);

        // Randomized traffic.
        rand_frame = 1;
        grants.delete();
        for (int i = 0; i < 3000; i++) begin
            cycle();
            req_valid = 4'($urandom);
            req_mask  = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'hF;
            req_data  = $urandom;
            err_clr   = ($urandom_range(15, 0) == 0);
            stray_clr = ($urandom_range(31, 0) == 0);
        end
        req_valid = '0;
        err_clr = 1'b0;
        stray_clr = 1'b0;
        repeat (40) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
